// File: rtl/psimd_instr_queue.sv
// Instruction issue queue feeding the PSIMD core: circular FIFO with a registered issue stage.
// Optional RAW interlock against the core's output register is enabled by defining PSIMD_IQ_HAZARD_EN.
module psimd_instr_queue #(
    parameter int                     DEPTH       = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [INSTR_WIDTH-1:0]       in_instr,
    output logic                         in_ready,
    input  logic                         issue_en,
    input  logic                         flush,
    output logic [INSTR_WIDTH-1:0]       instr_out,
    output logic                         instr_valid,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [INSTR_WIDTH-1:0] head;
    logic                   push;
    logic                   pop;
    logic                   hazard;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign head     = mem[rd_ptr];

`ifdef PSIMD_IQ_HAZARD_EN
    // The bubble itself issues with instr_valid=0, so the stall cannot repeat on the same head.
    logic [4:0] prev_rd;
    assign prev_rd = instr_out[11:7];
    assign hazard  = instr_valid &&
                     ((prev_rd == head[19:15]) ||
                      (prev_rd == head[24:20]) ||
                      (prev_rd == head[31:27]));
`else
    assign hazard = 1'b0;
`endif

    assign push = in_valid && !full && !flush;
    assign pop  = issue_en && !empty && !hazard && !flush;

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (issue_en) begin
            if (pop) begin
                instr_out   <= head;
                instr_valid <= 1'b1;
            end else begin
                instr_out   <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/psimd_instr_queue.md
Name: psimd_instr_queue

Overview:
Instruction issue queue directly upstream of the PSIMD core. Accepts 32-bit PSIMD instructions from the fetch/host side over a valid/ready handshake and buffers them in a circular FIFO. Presents exactly one registered instruction per enabled cycle on the core's instr input. When no instruction is available, it drives a NOP so the core's register file is never written spuriously.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
INSTR_WIDTH, 32, instruction width in bits.
NOP_INSTR, 32'h0000_0013, encoding issued when idle or flushed; the decoder treats it as wr_enable=0.

Ports:
clk  input  1  core clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream instruction valid.
in_instr  input  INSTR_WIDTH  upstream instruction.
in_ready  output  1  queue can accept; equals !full.
issue_en  input  1  core advance enable; 0 = core stalled, instr_out holds.
flush  input  1  synchronous discard of all queued and issued state.
instr_out  output  INSTR_WIDTH  instruction to the PSIMD core (registered).
instr_valid  output  1  instr_out carries a real popped instruction, not a NOP.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr and count = 0.
  - instr_out = NOP_INSTR, instr_valid = 0.
  - full = 0, empty = 1, in_ready = 1.
- Push: occurs when in_valid && in_ready. in_instr is written at wr_ptr; wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
- in_ready depends only on full. A push is refused when full, even if a pop happens in the same cycle.
- Issue on a rising edge with issue_en=1:
  - If not empty: instr_out <= mem[rd_ptr], instr_valid <= 1, rd_ptr increments modulo DEPTH.
  - If empty: instr_out <= NOP_INSTR, instr_valid <= 0.
- issue_en=0: instr_out, instr_valid and rd_ptr hold.
- Latency: an instruction pushed into an empty queue at edge N appears on instr_out at edge N+1 if issue_en=1. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- count updates: +1 on push only, -1 on pop only, unchanged otherwise.
- full and empty are decoded from the registered count.
- flush=1 has priority over push, pop and issue_en:
  - Pointers and count go to 0.
  - instr_out <= NOP_INSTR, instr_valid <= 0.
  - Any push in the same cycle is discarded; in_ready is still driven as !full.
- Reset asserted mid-operation: all state clears immediately with no clock required. Queued instructions are lost.
- instr_out is constant between enabled edges, which meets the core's combinational decode timing.

Optional Feature:
Macro: PSIMD_IQ_HAZARD_EN.
- Enabled: RAW interlock for the core's one-cycle output register.
  - The head instruction is held, and NOP_INSTR is issued with instr_valid=0, when all of the following hold:
    - the previously issued instruction has instr_valid=1;
    - its rd field [11:7] equals any of the head's rs1 [19:15], rs2 [24:20] or rs3 [31:27].
  - The bubble lasts exactly one enabled cycle; the head then issues.
  - count does not decrement in the bubble cycle.
  - flush clears the interlock state.
- Disabled: no comparison. The head always issues when not empty and issue_en=1.

Test Plan:
- Reset: rst_n=0 mid-stream with count=3 -> instr_out=32'h0000_0013, instr_valid=0, count=0, empty=1, in_ready=1, all without a clock edge.
- Fill: 8 pushes with issue_en=0 -> count=8, full=1, in_ready=0. A ninth push of 32'hDEAD_BEEF is dropped and never issued.
- Order and wrap-around: push A0..A11 while issuing continuously -> instr_out shows A0..A11 in order, each exactly one cycle after issue, with the pointers wrapping at entry 7.
- Simultaneous push/pop at count=4 -> count stays 4 and order is preserved. Empty with issue_en=1 -> NOP with instr_valid=0 every cycle.
- Flush with count=5, in_valid=1 and issue_en=1 in the same cycle -> count=0, instr_out=NOP, instr_valid=0; the pushed word is absent from later issue.
- PSIMD_IQ_HAZARD_EN: issue instr with rd=5, then head with rs2=5 -> one NOP bubble with instr_valid=0, then the head issues. Same sequence with the macro off -> back-to-back issue.
